// File: rtl/seq_pkg.sv
// Shared types and constants for the 9-bit-instruction control sequencer.
package seq_pkg;

  localparam int         PC_W        = 8;
  localparam int         JPTR_W      = 2;
  localparam logic [8:0] HALT_OP     = 9'h1FF;
  localparam int         MEM_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_e;

  // Entry 0 is the rightmost element of the packed array.
  localparam logic [2**JPTR_W-1:0][PC_W-1:0] JUMP_TARGETS = {8'h50, 8'h40, 8'h38, 8'h30};

endpackage

// File: rtl/jump_lut.sv
// Combinational jump-target ROM indexed by the low bits of the decoder jump pointer.
module jump_lut
  import seq_pkg::*;
(
  input  logic [JPTR_W-1:0] idx_i,
  output logic [PC_W-1:0]   target_o
);

  assign target_o = JUMP_TARGETS[idx_i];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning the program counter.
// Optional performance counters are built only when SEQ_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// FETCH  | instruction register load, halt detection
// EXEC   | ALU cycle, branch condition captured
// MEM    | data memory request held until MemAck or timeout
// WB     | register write and program counter update
// HALTED | program finished, waiting for Start
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT_P = MEM_TIMEOUT
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic [8:0]      Instr,
  input  logic            Ldr,
  input  logic            Str,
  input  logic            WenR,
  input  logic            IsBranch,
  input  logic            BranchTaken,
  input  logic [7:0]      Jptr,
  input  logic            MemAck,
  output logic [PC_W-1:0] ProgCtr,
  output logic            IrEn,
  output logic            RegWrEn,
  output logic            MemRdEn,
  output logic            MemWrEn,
  output logic            Busy,
  output logic            Done,
  output logic            MemErr
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]     InstrCount,
  output logic [15:0]     CycleCount
`endif
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT_P + 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
  logic                taken_q, taken_d;
  logic                regwr_q, regwr_d;
  logic                done_q, done_d;
  logic                memerr_q, memerr_d;
  logic                start_ok;
  logic [PC_W-1:0]     jump_tgt;
  logic                unused_jptr;

  assign unused_jptr = ^Jptr[7:JPTR_W];

  jump_lut u_jump_lut (
    .idx_i    (Jptr[JPTR_W-1:0]),
    .target_o (jump_tgt)
  );

  assign start_ok = Start & ((state_q == IDLE) | (state_q == HALTED));
  assign wcnt_inc = wcnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wcnt_d   = '0;
    taken_d  = taken_q;
    regwr_d  = 1'b0;
    done_d   = 1'b0;
    memerr_d = memerr_q;
    case (state_q)
      IDLE, HALTED: begin
        if (start_ok) begin
          pc_d     = StartAddr;
          memerr_d = 1'b0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (Instr == HALT_OP) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        taken_d = BranchTaken;
        if (Ldr | Str) begin
          state_d = MEM;
        end else begin
          state_d = WB;
          regwr_d = WenR & ~Str;
        end
      end
      MEM: begin
        if (MemAck) begin
          state_d = WB;
          regwr_d = WenR & ~Str;
        end else if (wcnt_inc == WCNT_W'(MEM_TIMEOUT_P)) begin
          // Timed-out access: give up, flag it, and skip the register write.
          state_d  = WB;
          memerr_d = 1'b1;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      WB: begin
        state_d = FETCH;
        if (IsBranch & taken_q) pc_d = jump_tgt;
        else                    pc_d = pc_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      wcnt_q   <= '0;
      taken_q  <= 1'b0;
      regwr_q  <= 1'b0;
      done_q   <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wcnt_q   <= wcnt_d;
      taken_q  <= taken_d;
      regwr_q  <= regwr_d;
      done_q   <= done_d;
      memerr_q <= memerr_d;
    end
  end

  assign ProgCtr = pc_q;
  assign IrEn    = (state_q == FETCH);
  assign Busy    = (state_q == FETCH) | (state_q == EXEC) | (state_q == MEM) | (state_q == WB);
  assign RegWrEn = regwr_q;
  assign Done    = done_q;
  assign MemErr  = memerr_q;
  assign MemRdEn = (state_q == MEM) & Ldr;
  assign MemWrEn = (state_q == MEM) & Str & ~Ldr;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] icnt_q, ccnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else if (start_ok) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (Busy && (ccnt_q != 16'hFFFF))             ccnt_q <= ccnt_q + 1'b1;
      if ((state_q == WB) && (icnt_q != 16'hFFFF))  icnt_q <= icnt_q + 1'b1;
    end
  end

  assign InstrCount = icnt_q;
  assign CycleCount = ccnt_q;
`endif

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit-instruction CPU.
- Owns the program counter and steps each instruction through FETCH/EXEC/MEM/WB.
- Gates the register-file and data-memory enables that the combinational decoder produces, and handles taken branches through a jump-target lookup table.
- Sits between the instruction ROM/decoder and the register file, ALU and data memory; the top level starts it and waits for Done.

Parameters:
PC_W, 8, program counter width
JPTR_W, 2, number of jump-pointer index bits used (LUT depth 2**JPTR_W)
HALT_OP, 9'h1FF, instruction word that halts the program
MEM_TIMEOUT, 15, maximum MEM cycles spent waiting for MemAck before an error is flagged

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  begin execution at StartAddr; sampled only in IDLE/HALTED
StartAddr  in  PC_W  first instruction address
Instr  in  9  instruction word from ROM at ProgCtr
Ldr  in  1  decoded load
Str  in  1  decoded store
WenR  in  1  decoded register write
IsBranch  in  1  decoded branch
BranchTaken  in  1  ALU branch condition, valid in EXEC
Jptr  in  8  jump pointer from decoder; low JPTR_W bits used
MemAck  in  1  data memory access complete
ProgCtr  out  PC_W  current program counter
IrEn  out  1  instruction register load strobe
RegWrEn  out  1  register file write enable
MemRdEn  out  1  data memory read request
MemWrEn  out  1  data memory write request
Busy  out  1  high in FETCH/EXEC/MEM/WB
Done  out  1  one-cycle pulse on entry to HALTED
MemErr  out  1  sticky; set on MEM timeout

Behaviour:
- Reset (async, Reset_n=0), including mid-instruction: state=IDLE, ProgCtr=0, MemErr=0, wait counter=0, all other outputs 0.
- IDLE: Start=1 loads ProgCtr<=StartAddr and moves to FETCH.
- FETCH: IrEn=1 for 1 cycle.
  - Instr==HALT_OP -> HALTED, with Done=1 in the first HALTED cycle.
  - Otherwise -> EXEC.
- EXEC: 1 cycle, registered outputs idle.
  - Ldr|Str -> MEM.
  - Otherwise -> WB.
  - BranchTaken is captured here.
- MEM:
  - MemRdEn=Ldr, MemWrEn=Str&~Ldr; Ldr has priority when both are set.
  - Requests are held until MemAck. MemAck in the first MEM cycle is legal -> WB on the next cycle.
  - Wait counter increments each MEM cycle without MemAck. Reaching MEM_TIMEOUT sets MemErr, drops the requests and moves to WB; that instruction's register write is suppressed.
- WB: RegWrEn = WenR & ~Str & ~timeout for 1 cycle. ProgCtr updates:
  - IsBranch & captured BranchTaken: ProgCtr <= jump_lut[Jptr[JPTR_W-1:0]].
  - Otherwise: ProgCtr+1, wrapping modulo 2**PC_W (all-ones -> 0).
  - Next state FETCH.
- HALTED:
  - ProgCtr holds; Busy=0.
  - Start=1 -> reload StartAddr -> FETCH. MemErr is cleared on Start.
- Start while Busy is ignored.
- Single-cycle instruction = 3 cycles (FETCH, EXEC, WB). Memory instruction = 4 + wait cycles.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs except MemRdEn/MemWrEn, which also use Ldr/Str.

Optional Feature:
- Macro SEQ_PERF_CNT_EN adds outputs InstrCount[15:0] and CycleCount[15:0].
  - Both are cleared on reset and on an accepted Start, and saturate at 16'hFFFF.
  - CycleCount increments every Busy cycle.
  - InstrCount increments on each WB exit.
- Without the macro, neither port nor counter logic exists.

Decomposition:
- Package seq_pkg: state enum (IDLE, FETCH, EXEC, MEM, WB, HALTED), HALT_OP constant, and jump-target constant array JUMP_TARGETS.
- Sub-module jump_lut: combinational ROM, JPTR_W index -> PC_W target, contents from seq_pkg.

Test Plan:
- Reset mid-MEM (Ldr=1, no MemAck) -> next cycle: ProgCtr=0, MemRdEn=0, Busy=0, state IDLE.
- StartAddr=8'h10, ROM[10]=ALU op with WenR=1, ROM[11]=HALT_OP -> IrEn at cycles 1 and 4, RegWrEn at cycle 3, Done pulse at cycle 5, ProgCtr=8'h11.
- Load at 8'h20, MemAck after 3 cycles -> MemRdEn high exactly 3 cycles, then RegWrEn=1 for 1 cycle, ProgCtr=8'h21.
- Store, MemAck never asserted -> MemErr=1 after 15 MEM cycles, RegWrEn stays 0, ProgCtr advances; a later Start clears MemErr.
- Branch, Jptr=2, BranchTaken=1, JUMP_TARGETS[2]=8'h40 -> ProgCtr=8'h40. Same with BranchTaken=0 -> ProgCtr+1.
- Non-branch at ProgCtr=8'hFF -> ProgCtr wraps to 8'h00. Start pulses while Busy have no effect.
